vip_fifo_reader: RTL and testbench

Synthesizable drain stage for the output FIFO of `vip_top`. It pops pixels with a read-request/empty handshake, tags each pixel with frame-position markers, and presents them on a valid/ready stream. It is the hardware counterpart of the bench-side image writer, and lets the VIP pipeline feed an on-chip sink such as a display or DMA engine. Frame geometry comes from the same `width`/`height`/`num_frame` bus the image generator drives.

---
 rtl/vip_fifo_reader.sv | 247 ++++++++++++++++++++++++
 tb/tb_vip_fifo_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_fifo_reader.sv
// vip_fifo_reader: drains the vip_top output FIFO, tags each pixel with
// start-of-frame / end-of-line / end-of-frame markers and presents the
// pixels on a valid/ready stream. Geometry is latched on an accepted start.
module vip_fifo_reader #(
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CWIDTH-1:0] width,
  input  logic [CWIDTH-1:0] height,
  input  logic [CWIDTH-1:0] num_frame,
  output logic              fifo_rdreq,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic [CWIDTH-1:0] frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Control state
  logic [1:0]        state_q, state_d;
  logic [CWIDTH-1:0] w_q, w_d, h_q, h_d, n_q, n_d;
  logic [CWIDTH-1:0] x_q, x_d, y_q, y_d, f_q, f_d;
  logic              issued_all_q, issued_all_d;
  logic [CWIDTH-1:0] frame_cnt_q, frame_cnt_d;

  // Read issued last cycle, with the markers computed when it was issued
  logic infl_q, infl_d;
  logic infl_sof_q, infl_sof_d;
  logic infl_eol_q, infl_eol_d;
  logic infl_eof_q, infl_eof_d;

  // Three-entry output buffer; entry 0 is the head and drives the outputs
  logic [2:0]        vld_q, vld_d;
  logic [DWIDTH-1:0] dat_q [3];
  logic [DWIDTH-1:0] dat_d [3];
  logic [2:0]        sof_q, sof_d;
  logic [2:0]        eol_q, eol_d;
  logic [2:0]        eof_q, eof_d;

  logic              geom_ok;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              final_hs;
  logic [1:0]        occ;
  logic              room;
  logic              x_last, y_last, f_last;
  logic              placed;

  assign geom_ok = (width != '0) && (height != '0) && (num_frame != '0);
  assign accept  = (state_q == S_IDLE) && start && geom_ok;

  assign occ  = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
  assign room = ({1'b0, occ} + {2'b00, infl_q}) <= 3'd2;

  // Pop decision depends only on registered state and FIFO flag, never on out_ready
  assign issue = (state_q == S_RUN) && !fifo_empty && !issued_all_q && room;

  assign pop      = vld_q[0] && out_ready;
  assign final_hs = (state_q == S_RUN) && pop && eof_q[0] &&
                    (frame_cnt_q == n_q - CWIDTH'(1));

  assign x_last = (x_q == w_q - CWIDTH'(1));
  assign y_last = (y_q == h_q - CWIDTH'(1));
  assign f_last = (f_q == n_q - CWIDTH'(1));

  // Job state machine
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = geom_ok ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (final_hs) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Geometry latch and issue-side position counters
  always_comb begin
    w_d          = w_q;
    h_d          = h_q;
    n_d          = n_q;
    x_d          = x_q;
    y_d          = y_q;
    f_d          = f_q;
    issued_all_d = issued_all_q;
    if (accept) begin
      w_d          = width;
      h_d          = height;
      n_d          = num_frame;
      x_d          = '0;
      y_d          = '0;
      f_d          = '0;
      issued_all_d = 1'b0;
    end else if (issue) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d = '0;
          if (f_last) begin
            issued_all_d = 1'b1;
          end else begin
            f_d = f_q + CWIDTH'(1);
          end
        end else begin
          y_d = y_q + CWIDTH'(1);
        end
      end else begin
        x_d = x_q + CWIDTH'(1);
      end
    end
  end

  // Markers ride alongside the read while it is in flight
  always_comb begin
    infl_d     = issue;
    infl_sof_d = 1'b0;
    infl_eol_d = 1'b0;
    infl_eof_d = 1'b0;
    if (issue) begin
      infl_sof_d = (x_q == '0) && (y_q == '0);
      infl_eol_d = x_last;
      infl_eof_d = x_last && y_last;
    end
  end

  // Output buffer: shift on pop, then land the returning beat in the first free slot
  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    sof_d  = sof_q;
    eol_d  = eol_q;
    eof_d  = eof_q;
    placed = 1'b0;
    if (pop) begin
      for (int unsigned i = 0; i < 2; i++) begin
        vld_d[i] = vld_q[i+1];
        dat_d[i] = dat_q[i+1];
        sof_d[i] = sof_q[i+1];
        eol_d[i] = eol_q[i+1];
        eof_d[i] = eof_q[i+1];
      end
      vld_d[2] = 1'b0;
    end
    if (infl_q) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!placed && !vld_d[i]) begin
          vld_d[i] = 1'b1;
          dat_d[i] = fifo_data;
          sof_d[i] = infl_sof_q;
          eol_d[i] = infl_eol_q;
          eof_d[i] = infl_eof_q;
          placed   = 1'b1;
        end
      end
    end
  end

  // Delivered-frame counter, saturating at the job's frame count
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      frame_cnt_d = '0;
    end else if (pop && eof_q[0] && (frame_cnt_q != n_q)) begin
      frame_cnt_d = frame_cnt_q + CWIDTH'(1);
    end
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      n_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      f_q          <= '0;
      issued_all_q <= 1'b0;
      frame_cnt_q  <= '0;
      infl_q       <= 1'b0;
      infl_sof_q   <= 1'b0;
      infl_eol_q   <= 1'b0;
      infl_eof_q   <= 1'b0;
      vld_q        <= '0;
      dat_q        <= '{default: '0};
      sof_q        <= '0;
      eol_q        <= '0;
      eof_q        <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      n_q          <= n_d;
      x_q          <= x_d;
      y_q          <= y_d;
      f_q          <= f_d;
      issued_all_q <= issued_all_d;
      frame_cnt_q  <= frame_cnt_d;
      infl_q       <= infl_d;
      infl_sof_q   <= infl_sof_d;
      infl_eol_q   <= infl_eol_d;
      infl_eof_q   <= infl_eof_d;
      vld_q        <= vld_d;
      dat_q        <= dat_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
    end
  end

  assign fifo_rdreq = issue;
  assign out_data   = dat_q[0];
  assign out_valid  = vld_q[0];
  assign out_sof    = vld_q[0] & sof_q[0];
  assign out_eol    = vld_q[0] & eol_q[0];
  assign out_eof    = vld_q[0] & eof_q[0];
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vip_fifo_reader.sv
// Bench for vip_fifo_reader: bench-side FIFO model, expected pixel stream
// derived from frame geometry, per-cycle comparison plus directed scenarios.
module tb_vip_fifo_reader;

  localparam int DW = 24;
  localparam int CW = 11;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          l;
    logic          e;
  } pix_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] width = '0, height = '0, num_frame = '0;
  logic          fifo_rdreq;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof, out_eol, out_eof, busy, done;
  logic [CW-1:0] frame_cnt;

  vip_fifo_reader #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .width(width), .height(height), .num_frame(num_frame),
    .fifo_rdreq(fifo_rdreq), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Bench FIFO contents and expected output stream
  logic [DW-1:0] src_q [$];
  pix_t          exp_q [$];

  // Model state
  bit            model_on = 1'b0;
  bit            job_active = 1'b0;
  bit            done_due = 1'b0;
  int            frames_m = 0;
  int            n_m = 0;
  int            job_total = 0;
  int            pops = 0;
  int            hs = 0;
  logic [63:0]   sof_mask, eol_mask, eof_mask;
  logic [DW-1:0] last_data;
  int            cyc = 0;
  int            last_hs_cyc = 0;
  int            first_rd_cyc = -1;
  int            first_vld_cyc = -1;
  bit            stall_prev = 1'b0;
  logic [DW+3:0] stall_snap;
  bit            pop_pending = 1'b0;
  logic [DW-1:0] data_next;
  int            gap_cnt = 0;
  int            ready_mode = 0;
  bit            rnd_empty = 1'b0;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // FIFO / sink driver: inputs change 1 time unit after the rising edge
  always @(posedge clock) begin
    #1;
    cyc++;
    if (pop_pending) fifo_data = data_next;
    else             fifo_data = DW'($urandom);
    pop_pending = 1'b0;
    fifo_empty = (src_q.size() == 0) || (gap_cnt > 0) ||
                 (rnd_empty && ($urandom_range(0, 3) == 0));
    if (gap_cnt > 0) gap_cnt--;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[cyc % 4];
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clock) begin
    bit   nxt_done;
    pix_t e;
    if (model_on) begin
      nxt_done = 1'b0;
      chk("done", done, done_due);
      chk("busy", busy, job_active);
      chk("frame_cnt", frame_cnt, frames_m);
      chk("rdreq_while_empty", fifo_rdreq && fifo_empty, 0);
      chk("rdreq_over_budget", fifo_rdreq && (pops >= job_total), 0);
      if (fifo_rdreq && !fifo_empty && (pops < job_total)) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        data_next   = src_q.pop_front();
        pop_pending = 1'b1;
        pops++;
      end
      chk("occupancy_bound", (pops - hs) > 3, 0);
      if (stall_prev)
        chk("stall_hold", {out_valid, out_data, out_sof, out_eol, out_eof}, stall_snap);
      chk("valid_without_pixel", out_valid && (exp_q.size() == 0), 0);
      if (out_valid && (exp_q.size() != 0)) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        e = exp_q[0];
        chk("pixel", {out_data, out_sof, out_eol, out_eof}, e);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (hs < 64) begin
            sof_mask[hs] = out_sof;
            eol_mask[hs] = out_eol;
            eof_mask[hs] = out_eof;
          end
          last_data   = out_data;
          last_hs_cyc = cyc;
          hs++;
          if (e.e && (frames_m < n_m)) frames_m++;
          if (job_active && (hs == job_total)) begin
            job_active = 1'b0;
            nxt_done   = 1'b1;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_snap = {out_valid, out_data, out_sof, out_eol, out_eof};
      if (!job_active && !done_due && start) begin
        if (width == 0 || height == 0 || num_frame == 0) begin
          nxt_done = 1'b1;
        end else begin
          job_active = 1'b1;
          frames_m   = 0;
          n_m        = int'(num_frame);
        end
      end
      done_due = nxt_done;
    end
  end

  task automatic load_job(input int w, input int h, input int n, input bit seq, input int base);
    logic [DW-1:0] v;
    int x, y;
    src_q.delete();
    exp_q.delete();
    job_total = w * h * n;
    for (int k = 0; k < job_total; k++) begin
      v = seq ? DW'(base + k) : DW'($urandom);
      x = k % w;
      y = (k / w) % h;
      src_q.push_back(v);
      exp_q.push_back('{d: v, s: (x == 0 && y == 0), l: (x == w - 1),
                        e: (x == w - 1 && y == h - 1)});
    end
    pops = 0;
    hs = 0;
    sof_mask = '0;
    eol_mask = '0;
    eof_mask = '0;
    first_rd_cyc = -1;
    first_vld_cyc = -1;
  endtask

  task automatic pulse_start(input int w, input int h, input int n);
    @(posedge clock);
    #1;
    width = CW'(w);
    height = CW'(h);
    num_frame = CW'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done) break;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (hs >= target) break;
    end
    chk("reach_pixel", hs >= target, 1);
  endtask

  initial begin
    int done_cyc;
    // Reset values, while reset is held
    #1;
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_markers", {out_sof, out_eol, out_eof}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_on = 1'b1;

    // 4x2x2 job, values 0..15, sink always ready
    load_job(4, 2, 2, 1'b1, 0);
    pulse_start(4, 2, 2);
    wait_done("A_done");
    done_cyc = cyc;
    chk("A_sof_mask", sof_mask, 64'h0101);
    chk("A_eol_mask", eol_mask, 64'h8888);
    chk("A_eof_mask", eof_mask, 64'h8080);
    chk("A_pops", pops, 16);
    chk("A_outputs", hs, 16);
    chk("A_last_value", last_data, 15);
    chk("A_frame_cnt", frame_cnt, 2);
    chk("A_done_latency", done_cyc - last_hs_cyc, 1);
    chk("A_read_latency", first_vld_cyc - first_rd_cyc, 2);
    @(negedge clock);
    chk("A_done_pulse_width", done, 0);

    // Same job, sink pattern 1,0,0,1
    ready_mode = 1;
    load_job(4, 2, 2, 1'b1, 0);
    pulse_start(4, 2, 2);
    wait_done("B_done");
    chk("B_outputs", hs, 16);
    chk("B_last_value", last_data, 15);
    chk("B_eof_mask", eof_mask, 64'h8080);

    // Same job with a 5-cycle empty gap mid-line
    ready_mode = 0;
    load_job(4, 2, 2, 1'b1, 0);
    pulse_start(4, 2, 2);
    wait_hs(2);
    gap_cnt = 5;
    wait_done("C_done");
    chk("C_eol_count", $countones(eol_mask), 4);
    chk("C_eol_mask", eol_mask, 64'h8888);

    // Zero height: immediate done, no reads, never busy
    load_job(4, 0, 2, 1'b1, 0);
    pulse_start(4, 0, 2);
    @(negedge clock);
    chk("Z_done", done, 1);
    chk("Z_busy", busy, 0);
    chk("Z_pops", pops, 0);
    @(negedge clock);
    chk("Z_done_width", done, 0);

    // Randomized jobs with random sink stalls and FIFO underruns
    ready_mode = 2;
    rnd_empty = 1'b1;
    for (int j = 0; j < 6; j++) begin
      int w, h, n;
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 3);
      n = $urandom_range(1, 3);
      load_job(w, h, n, 1'b0, 0);
      pulse_start(w, h, n);
      wait_done("R_done");
      chk("R_outputs", hs, w * h * n);
      chk("R_frame_cnt", frame_cnt, n);
    end
    rnd_empty = 1'b0;

    // Start pulsed mid-job must be ignored
    ready_mode = 0;
    load_job(3, 2, 2, 1'b1, 40);
    pulse_start(3, 2, 2);
    wait_hs(3);
    pulse_start(1, 1, 1);
    wait_done("S_done");
    chk("S_outputs", hs, 12);
    chk("S_frame_cnt", frame_cnt, 2);
    chk("S_last_value", last_data, 51);

    // Reset in the middle of a 4x2x1 job, then a 2x1x1 job
    load_job(4, 2, 1, 1'b1, 0);
    pulse_start(4, 2, 1);
    wait_hs(5);
    @(posedge clock);
    #2;
    model_on = 1'b0;
    reset = 1'b1;
    #1;
    chk("X_rdreq", fifo_rdreq, 0);
    chk("X_valid", out_valid, 0);
    chk("X_data", out_data, 0);
    chk("X_markers", {out_sof, out_eol, out_eof}, 0);
    chk("X_busy_done", {busy, done}, 0);
    chk("X_frame_cnt", frame_cnt, 0);
    #1;
    reset = 1'b0;
    load_job(2, 1, 1, 1'b1, 100);
    job_active = 1'b0;
    done_due = 1'b0;
    frames_m = 0;
    stall_prev = 1'b0;
    pop_pending = 1'b0;
    model_on = 1'b1;
    pulse_start(2, 1, 1);
    wait_done("X_done");
    chk("X_outputs", hs, 2);
    chk("X_sof_mask", sof_mask, 64'h1);
    chk("X_eol_mask", eol_mask, 64'h2);
    chk("X_eof_mask", eof_mask, 64'h2);
    chk("X_last_value", last_data, 101);
    @(negedge clock);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
